// File: rtl/poly1305_mod_reduce.sv
// poly1305_mod_reduce
//   Reduces a multiplier product modulo p = 2^P_BITS - FOLD_C to a canonical
//   value in [0, p-1]. Each busy cycle performs one fold, acc = lo + C*hi,
//   until hi is zero. A final conditional subtract of p then finishes the job.
//   The start/busy/done handshake matches the multiplier's, so product_out/done
//   of that block can drive product_in/start here directly.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      request, sampled only while busy=0
//   product_in value to reduce, sampled on the accepting edge
//   result_out reduced value, held until the next done
//   busy       high while a reduction is in progress
//   done       one-cycle pulse when result_out is updated
module poly1305_mod_reduce #(
    parameter int P_BITS  = 130,
    parameter int IN_BITS = 258,
    parameter int FOLD_C  = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [IN_BITS-1:0] product_in,
    output logic [P_BITS-1:0]  result_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, FOLD, FINAL} state_t;

    // p = 2^P_BITS - FOLD_C, built as all-ones minus (C-1) to avoid 2**P_BITS overflow
    localparam logic [P_BITS-1:0] P_MOD = {P_BITS{1'b1}} - P_BITS'(FOLD_C - 1);

    state_t                     state;
    logic [IN_BITS-1:0]         acc;
    logic [IN_BITS-P_BITS-1:0]  hi;
    logic [P_BITS-1:0]          lo;
    logic [IN_BITS-1:0]         fold_sum;
    logic [P_BITS-1:0]          final_val;

    assign hi = acc[IN_BITS-1:P_BITS];
    assign lo = acc[P_BITS-1:0];

    // Full IN_BITS-wide arithmetic. The first fold needs up to P_BITS+2 bits,
    // so nothing can truncate here. The multiply by a constant reduces to shifts and adds.
    assign fold_sum = IN_BITS'(lo) + hi * IN_BITS'(FOLD_C);

    assign final_val = (lo >= P_MOD) ? lo - P_MOD : lo;

    // The FINAL step is taken inside FOLD on the edge where hi==0.
    // Otherwise k folds would cost k+2 cycles instead of k+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            acc        <= '0;
            result_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= product_in;
                        busy  <= 1'b1;
                        state <= FOLD;
                    end
                end
                FOLD: begin
                    if (|hi) begin
                        acc <= fold_sum;
                    end else begin
                        result_out <= final_val;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                FINAL: begin
                    result_out <= final_val;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly1305_mod_reduce.sv
// Testbench for poly1305_mod_reduce.
// Stimulus pushes expected results into a queue. A negedge monitor pops one
// entry on each done pulse and checks the value, the latency and the busy duration.
module tb_poly1305_mod_reduce;

    localparam int P_BITS  = 130;
    localparam int IN_BITS = 258;
    localparam int FOLD_C  = 5;

    localparam logic [263:0] ONE  = 264'd1;
    localparam logic [263:0] PM   = (ONE << 130) - 264'd5;
    localparam logic [263:0] MASK = (ONE << 130) - 264'd1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [IN_BITS-1:0] product_in = '0;
    logic [P_BITS-1:0]  result_out;
    logic               busy;
    logic               done;

    poly1305_mod_reduce #(.P_BITS(P_BITS), .IN_BITS(IN_BITS), .FOLD_C(FOLD_C)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .product_in (product_in),
        .result_out (result_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [P_BITS-1:0] res;
        int                k;
        int                acc_cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the true residue, plus the fold count from the plain arithmetic rule
    function automatic logic [P_BITS-1:0] ref_mod(input logic [263:0] x);
        logic [263:0] r;
        r = x % PM;
        return r[P_BITS-1:0];
    endfunction

    function automatic int ref_folds(input logic [263:0] x);
        int k = 0;
        while ((x >> 130) != 0) begin
            x = (x >> 130) * 264'd5 + (x & MASK);
            k++;
        end
        return k;
    endfunction

    function automatic logic [IN_BITS-1:0] rand_in();
        logic [287:0] t;
        logic [263:0] v;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        v = {(264 - 258){1'b0}} | 264'(t[257:0]);
        case ($urandom_range(0, 4))
            0: v = v & MASK;                              // k=0 region
            1: v = v & ((ONE << 131) - 1);                // one fold
            2: v = PM + 264'($urandom_range(0, 8)) - 264'd4; // around p
            3: v = (v & ((ONE << 130) - 1)) * (v >> 130); // chained multiplier output
            default: ;
        endcase
        return v[IN_BITS-1:0];
    endfunction

    function automatic void push_exp(input logic [IN_BITS-1:0] x, input int acc_cyc);
        exp_t e;
        e.res     = ref_mod(264'(x));
        e.k       = ref_folds(264'(x));
        e.acc_cyc = acc_cyc;
        q.push_back(e);
    endfunction

    // Monitor
    int busy_run  = 0;
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                checks++;
                if (prev_done) begin
                    failures++;
                    $display("FAIL done_pulse: done high two cycles in a row");
                end
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: result=%h with no pending request", result_out);
                end else begin
                    e = q.pop_front();
                    checks += 4;
                    if (result_out !== e.res) begin
                        failures++;
                        $display("FAIL result: got %h expected %h", result_out, e.res);
                    end
                    if (cyc - e.acc_cyc != e.k + 1) begin
                        failures++;
                        $display("FAIL latency: got %0d expected %0d", cyc - e.acc_cyc, e.k + 1);
                    end
                    if (busy_run != e.k + 1) begin
                        failures++;
                        $display("FAIL busy_len: got %0d expected %0d", busy_run, e.k + 1);
                    end
                    if (busy !== 1'b0) begin
                        failures++;
                        $display("FAIL busy_at_done: got %b expected 0", busy);
                    end
                end
                busy_run = 0;
            end
            prev_done = done;
        end
    end

    // Wait (from posedge+1) until busy is low, bounded
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++; failures++;
            $display("FAIL idle_timeout: busy=%b expected 0", busy);
        end
    endtask

    // One request with a single-cycle start; product_in is scrambled after acceptance
    task automatic issue(input logic [IN_BITS-1:0] x);
        @(posedge clk); #1;
        wait_idle();
        start      = 1'b1;
        product_in = x;
        push_exp(x, cyc + 1);
        @(posedge clk); #1;
        start      = 1'b0;
        product_in = rand_in();
    endtask

    // start held high while product_in changes every cycle; only idle edges accept
    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start      = 1'b1;
            product_in = rand_in();
            if (!busy) push_exp(product_in, cyc + 1);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic chk(input string name, input logic [P_BITS-1:0] got, input logic [P_BITS-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        logic [263:0] v;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", P_BITS'(busy), '0);
        chk("rst_done", P_BITS'(done), '0);
        chk("rst_result", result_out, '0);
        reset_n = 1'b1;

        // Directed boundaries
        issue('0);
        v = PM;                         issue(v[IN_BITS-1:0]);
        v = MASK;                       issue(v[IN_BITS-1:0]);
        v = ONE << 130;                 issue(v[IN_BITS-1:0]);
        v = (ONE << 131) - 264'd6;      issue(v[IN_BITS-1:0]);
        v = (ONE << 258) - 1;           issue(v[IN_BITS-1:0]);
        v = PM - 1;                     issue(v[IN_BITS-1:0]);

        // Held start, product_in changing while busy
        stream(40);

        // Reset in the middle of a 2-fold reduction, between E1 and E2
        @(posedge clk); #1;
        wait_idle();
        @(posedge clk); #1;
        v = (ONE << 258) - 1;
        issue(v[IN_BITS-1:0]);          // returns just after E1
        reset_n = 1'b0;
        #1;
        q.delete();
        chk("abort_busy", P_BITS'(busy), '0);
        chk("abort_done", P_BITS'(done), '0);
        chk("abort_result", result_out, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", P_BITS'(done), '0);
        reset_n = 1'b1;
        v = (ONE << 258) - 1;
        issue(v[IN_BITS-1:0]);

        // Random regression
        for (int i = 0; i < 1000; i++) issue(rand_in());
        stream(200);

        // Drain
        for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
